// File: rtl/mixer_if_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mixer_if_demod: square-wave NCO downmixer with integrate-and-dump output |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mixer_if_demod #(
  parameter int DW  = 12,
  parameter int PW  = 16,
  parameter int DEC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [PW-1:0]        phase_inc,
  input  logic                 s_valid,
  input  logic signed [DW-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic signed [DW+8:0] m_data,
  output logic                 overrun
);

  localparam int OW = DW + 9;
  localparam int CW = (DEC > 2) ? $clog2(DEC) : 1;
  localparam logic [CW-1:0] c_last = CW'(DEC - 1);

  logic [PW-1:0]        r_phase;
  logic signed [OW-1:0] r_acc;
  logic [CW-1:0]        r_count;

  logic signed [DW:0]   w_ext;
  logic signed [DW:0]   w_prod;
  logic signed [OW-1:0] w_prod_ext;
  logic signed [OW-1:0] w_sum;
  logic                 w_dump;

  // One extra bit so negating the most negative sample is exact.
  assign w_ext      = {s_data[DW-1], s_data};
  assign w_prod     = r_phase[PW-1] ? -w_ext : w_ext;
  assign w_prod_ext = {{(OW-DW-1){w_prod[DW]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;
  assign w_dump     = s_valid && (r_count == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_count <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      overrun <= 1'b0;
    end else if (clear) begin
      r_phase <= '0;
      r_acc   <= '0;
      r_count <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (s_valid) begin
        r_phase <= r_phase + phase_inc;
        if (w_dump) begin
          r_acc   <= '0;
          r_count <= '0;
          // A result consumed this cycle frees the register for the new one.
          if (!m_valid || m_ready) begin
            m_valid <= 1'b1;
            m_data  <= w_sum;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          r_acc   <= w_sum;
          r_count <= r_count + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mixer_if_demod.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mixer_if_demod: scoreboard bench for two decimation settings          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mixer_if_demod;

  logic               clk;
  logic               rst_n;
  logic               clear;
  logic [15:0]        phase_inc;
  logic               s_valid;
  logic signed [11:0] s_data;
  logic               rdy0, rdy1;
  logic               m_valid0, m_valid1;
  logic signed [20:0] m_data0, m_data1;
  logic               overrun0, overrun1;

  int nchk = 0;
  int nerr = 0;

  mixer_if_demod #(.DW(12), .PW(16), .DEC(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .phase_inc(phase_inc),
    .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid0), .m_ready(rdy0),
    .m_data(m_data0), .overrun(overrun0)
  );

  mixer_if_demod #(.DW(12), .PW(16), .DEC(256)) u_dut_fs (
    .clk(clk), .rst_n(rst_n), .clear(clear), .phase_inc(phase_inc),
    .s_valid(s_valid), .s_data(s_data), .m_valid(m_valid1), .m_ready(rdy1),
    .m_data(m_data1), .overrun(overrun1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: LO = +1/-1 from the upper half of the phase circle.
  int unsigned mph[2];
  longint      macc[2];
  int          mcnt[2];
  bit          mfull[2];
  bit          movr[2];
  longint      q0[$];
  longint      q1[$];
  longint      last0 = 0;
  longint      last1 = 0;

  task automatic mstep(input int k, input int dec, input bit rdy);
    longint prod;
    if (clear) begin
      mph[k] = 0; macc[k] = 0; mcnt[k] = 0; mfull[k] = 0; movr[k] = 0;
      return;
    end
    if (mfull[k] && rdy) mfull[k] = 0;
    if (s_valid) begin
      prod    = (mph[k] >= 32768) ? -longint'(s_data) : longint'(s_data);
      mph[k]  = (mph[k] + int'(phase_inc)) % 65536;
      macc[k] += prod;
      mcnt[k]++;
      if (mcnt[k] == dec) begin
        if (!mfull[k]) begin
          if (k == 0) q0.push_back(macc[k]); else q1.push_back(macc[k]);
          mfull[k] = 1;
        end else begin
          movr[k] = 1;
        end
        macc[k] = 0;
        mcnt[k] = 0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mph[k] = 0; macc[k] = 0; mcnt[k] = 0; mfull[k] = 0; movr[k] = 0;
      end
    end else begin
      mstep(0, 16, rdy0);
      mstep(1, 256, rdy1);
    end
  end

  // Monitor: exactly mfull entries should be pending at each falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!mfull[0]) q0.delete();
      if (!mfull[1]) q1.delete();
      check("m_valid0", longint'(m_valid0), longint'(mfull[0]));
      check("overrun0", longint'(overrun0), longint'(movr[0]));
      check("m_valid1", longint'(m_valid1), longint'(mfull[1]));
      check("overrun1", longint'(overrun1), longint'(movr[1]));
      if (m_valid0 && q0.size() > 0) begin
        check("m_data0", longint'(m_data0), q0[0]);
        if (rdy0) last0 = q0.pop_front();
      end
      if (m_valid1 && q1.size() > 0) begin
        check("m_data1", longint'(m_data1), q1[0]);
        if (rdy1) last1 = q1.pop_front();
      end
    end
  end

  task automatic cyc(input bit v, input int d);
    s_valid = v;
    s_data  = 12'(d);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic feed(input int n, input int a, input int b);
    for (int i = 0; i < n; i++) cyc(1'b1, (i % 2 == 1) ? b : a);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; phase_inc = '0; s_valid = 1'b0; s_data = '0;
    rdy0 = 1'b1; rdy1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", longint'(m_valid0), 0);
    check("rst_m_data", longint'(m_data0), 0);
    check("rst_overrun", longint'(overrun0), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // DC with a fixed LO
    feed(16, 100, 100);
    check("dc_valid", longint'(m_valid0), 1);
    check("dc_data", longint'(m_data0), 1600);
    cyc(1'b0, 0);
    check("dc_pulse", longint'(m_valid0), 0);
    check("dc_last", last0, 1600);

    // Mixing with LO toggling every sample
    do_clear();
    phase_inc = 16'h8000;
    feed(16, 100, 100);   cyc(1'b0, 0); check("mix_const", last0, 0);
    feed(16, 100, -100);  cyc(1'b0, 0); check("mix_alt_pos", last0, 1600);
    feed(16, -100, 100);  cyc(1'b0, 0); check("mix_alt_neg", last0, -1600);

    // Full scale on the DEC=256 instance
    do_clear();
    feed(256, -2048, 2047); cyc(1'b0, 0);
    check("fs_alt", last1, -524160);
    do_clear();
    feed(1, 0, 0);
    phase_inc = 16'h0000;
    feed(255, -2048, -2048); cyc(1'b0, 0);
    check("fs_first_frame", last1, 522240);
    feed(256, -2048, -2048); cyc(1'b0, 0);
    check("fs_neg_lo", last1, 524288);

    // Backpressure and overrun
    do_clear();
    rdy0 = 1'b0;
    feed(32, 10, 10); cyc(1'b0, 0);
    check("bp_valid", longint'(m_valid0), 1);
    check("bp_held", longint'(m_data0), 160);
    check("bp_overrun", longint'(overrun0), 1);
    rdy0 = 1'b1;
    cyc(1'b0, 0);
    check("bp_drained", longint'(m_valid0), 0);
    check("bp_sticky", longint'(overrun0), 1);
    check("bp_last", last0, 160);
    do_clear();
    check("bp_clear", longint'(overrun0), 0);

    // Consume and dump on the same edge
    rdy0 = 1'b0;
    feed(16, 10, 10);
    feed(15, 20, 20);
    rdy0 = 1'b1;
    cyc(1'b1, 20);
    rdy0 = 1'b0;
    check("sim_valid", longint'(m_valid0), 1);
    check("sim_data", longint'(m_data0), 320);
    check("sim_overrun", longint'(overrun0), 0);
    check("sim_first", last0, 160);
    rdy0 = 1'b1;
    cyc(1'b0, 0);
    check("sim_second", last0, 320);

    // Clear mid-frame
    feed(5, 10, 10);
    do_clear();
    feed(16, 10, 10); cyc(1'b0, 0);
    check("clr_frame", last0, 160);

    // Asynchronous reset between clock edges
    feed(16, 30, 30);
    feed(7, 10, 10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", longint'(m_valid0), 0);
    check("arst_data", longint'(m_data0), 0);
    check("arst_overrun", longint'(overrun0), 0);
    check("arst_data_fs", longint'(m_data1), 0);
    #1 rst_n = 1'b1;
    feed(16, 25, 25); cyc(1'b0, 0);
    check("arst_frame", last0, 400);

    // Randomized traffic with random backpressure and occasional retuning
    for (int i = 0; i < 3000; i++) begin
      rdy0 = ($urandom_range(0, 3) != 0);
      rdy1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) phase_inc = 16'($urandom);
      clear = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 4) != 0, int'($urandom_range(0, 4095)) - 2048);
      clear = 1'b0;
    end
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    repeat (10) cyc(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mixer_if_demod.md
# mixer_if_demod

Digital downconversion stage that sits after the ADC on the active mixer's differential output (pos − neg). It multiplies each incoming IF sample by a square-wave local oscillator (LO) and integrates the result over a fixed number of samples (integrate-and-dump) to recover the baseband RF envelope. The LO is a phase-accumulator numerically controlled oscillator (NCO), and its sign switching mirrors the mixer's LO-driven differential pair. Results leave on a valid/ready stream with single-register buffering and overrun flagging.

## Interface
- DW, 12: input sample width, two's complement.
- PW, 16: NCO phase accumulator width.
- DEC, 16: samples per output result; legal range 2..256.
- OW (localparam) = DW+9: output width; no overflow is possible for any DEC ≤ 256.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous soft reset of the datapath.
- phase_inc  in  PW  NCO increment per accepted sample; may change at any time.
- s_valid  in  1  input sample strobe. Always accepted; there is no s_ready.
- s_data  in  DW  signed IF sample (pos − neg).
- m_valid  out  1  result available.
- m_ready  in  1  downstream accepts the result.
- m_data  out  OW  signed integrated result.
- overrun  out  1  sticky flag: a result was dropped.

## Operation
- Reset (rst_n low) values: phase = 0, acc = 0, count = 0, m_valid = 0, m_data = 0, overrun = 0.
- The LO sign is the phase MSB.
  - MSB = 0: the product is +s_data.
  - MSB = 1: the product is −s_data.
  - Before negating, sign-extend to DW+1 bits so that −(−2^(DW−1)) is exact.
- On each cycle with s_valid = 1 and clear = 0:
  - The product uses the current phase.
  - Phase updates to phase + phase_inc, mod 2^PW.
  - count increments.
- Dump: when the accepted sample is the DEC-th one (count = DEC−1):
  - acc + product is the result.
  - acc ← 0 and count ← 0.
  - Phase is NOT reset; it runs continuously across frames.
- Output register states:
  - EMPTY → FULL on a dump.
  - FULL → EMPTY on m_valid & m_ready, unless a dump occurs in the same cycle. In that case the register stays FULL and loads the new result.
  - A dump while FULL and m_ready = 0: the new result is discarded, the old m_data is held, and overrun ← 1.
- clear = 1: phase, acc, count, m_valid and overrun all go to 0.
  - m_data is held.
  - clear takes priority over s_valid in the same cycle; that sample is discarded.
- Arithmetic: acc and m_data are OW-bit signed, and every sum is exact.

## Timing
- m_valid rises on the clock edge that accepts the DEC-th sample, so the result is visible in the following cycle.
- Throughput: one sample per cycle, sustained. With no backpressure, one result every DEC accepted samples.
- Gaps in s_valid only stretch the frame; they do not alter the result.
- m_data is stable while m_valid = 1 and m_ready = 0.
- rst_n asserted mid-frame clears all state immediately, with no dependence on the clock. Release is synchronized externally.
- A change to phase_inc takes effect on the next accepted sample.

## Test plan
- DC, LO fixed:
  - Setup: phase_inc = 0, DEC = 16, 16 samples of s_data = 100, m_ready = 1.
  - Required: m_data = 1600, with m_valid high for exactly 1 cycle, one cycle after the 16th sample.
- Mixing:
  - Setup: phase_inc = 0x8000, so the LO runs +1, −1, … starting at +1.
  - Constant input 100 for 16 samples → m_data = 0.
  - Input alternating +100, −100 → m_data = 1600.
  - Input alternating −100, +100 → m_data = −1600.
- Full scale:
  - Setup: DEC = 256, phase_inc = 2^(PW−1), input alternating −2048, +2047.
  - Required: m_data = 256·(−2048) + … = −524160 exactly, with no wrap.
  - Also: constant −2048 with LO stuck at −1 (phase preloaded via 0x8000 steps) → +524288.
- Backpressure and overrun:
  - Setup: m_ready = 0 across two full frames of input 10.
  - Required: the first result (160) is held, overrun = 1 after the second dump.
  - Then m_ready = 1 → the 160 transfers, m_valid = 0, and overrun stays 1 until clear.
- Simultaneous consume and dump:
  - Setup: m_ready pulses high on the exact cycle of the next dump.
  - Required: m_valid stays high, m_data updates to the new value, overrun = 0.
- Clear and reset mid-frame:
  - Clear after 5 samples, then 16 samples of 10 → m_data = 160.
  - rst_n pulse (asynchronous, between clock edges) after 7 samples → all outputs 0 immediately, and the next full frame yields the correct sum.
